// File: rtl/alu_result_queue_pkg.sv
// alu_pkg: ALU opcode enum and the queue entry layout (parity field under ALU_RQ_PARITY_EN)
package alu_pkg;

    localparam int ALU_W = 64;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'd0,
        ALU_OP_SUB = 2'd1,
        ALU_OP_AND = 2'd2,
        ALU_OP_XOR = 2'd3
    } alu_op_t;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             overflow;
        logic             zero;
        logic [1:0]       control;
`ifdef ALU_RQ_PARITY_EN
        logic             parity;
`endif
    } rq_entry_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// alu_result_queue_if: ALU-side push, consumer-side pop and status bundle; out_parity under ALU_RQ_PARITY_EN
interface alu_result_queue_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_result;
    logic                     in_overflow;
    logic [1:0]               in_control;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_result;
    logic                     out_overflow;
    logic                     out_zero;
    logic [1:0]               out_control;
    logic                     ovf_sticky;
    logic [CNT_W-1:0]         ovf_count;
    logic                     clr_status;
    logic [$clog2(DEPTH):0]   level;
`ifdef ALU_RQ_PARITY_EN
    logic                     out_parity;
`endif

    modport slave (
        input  in_valid, in_result, in_overflow, in_control, out_ready, clr_status,
        output in_ready, out_valid, out_result, out_overflow, out_zero, out_control,
               ovf_sticky, ovf_count, level
`ifdef ALU_RQ_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_valid, in_result, in_overflow, in_control, out_ready, clr_status,
        input  in_ready, out_valid, out_result, out_overflow, out_zero, out_control,
               ovf_sticky, ovf_count, level
`ifdef ALU_RQ_PARITY_EN
        , input out_parity
`endif
    );

endinterface

// File: rtl/alu_result_queue_mem.sv
// alu_rq_mem: reset-free DEPTH-entry register array, one write port, one asynchronous read port
module alu_rq_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  rq_entry_t                i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output rq_entry_t                o_rdata
);
    rq_entry_t r_mem [DEPTH];

    // capture the entry on push; contents need no reset since level gates validity
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: registered FIFO of ALU results with zero flag, masked overflow and sticky/saturating overflow status; ALU_RQ_PARITY_EN adds per-entry parity
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    alu_result_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    rq_entry_t        w_wdata;
    rq_entry_t        w_head;

    assign q.in_ready  = r_level != LW'(DEPTH);
    assign q.out_valid = r_level != '0;
    assign w_push      = q.in_valid & q.in_ready;
    assign w_pop       = q.out_valid & q.out_ready;
    assign w_ovf       = q.in_overflow & (q.in_control == ALU_OP_ADD || q.in_control == ALU_OP_SUB);

    // build the stored entry: logic ops never report overflow, zero is resolved at enqueue
    always_comb begin
        w_wdata          = '0;
        w_wdata.result   = q.in_result;
        w_wdata.overflow = w_ovf;
        w_wdata.zero     = q.in_result == '0;
        w_wdata.control  = q.in_control;
`ifdef ALU_RQ_PARITY_EN
        w_wdata.parity   = ^q.in_result;
`endif
    end

    alu_rq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // pointers wrap naturally at power-of-two depth; level tells full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // overflow status: an overflowing push beats a simultaneous clear and restarts the count at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_push && w_ovf) begin
            r_sticky <= 1'b1;
            r_count  <= q.clr_status ? CNT_W'(1) : (&r_count ? r_count : r_count + 1'b1);
        end else if (q.clr_status) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end
    end

    assign q.out_result   = w_head.result;
    assign q.out_overflow = w_head.overflow;
    assign q.out_zero     = w_head.zero;
    assign q.out_control  = w_head.control;
`ifdef ALU_RQ_PARITY_EN
    assign q.out_parity   = w_head.parity;
`endif
    assign q.ovf_sticky   = r_sticky;
    assign q.ovf_count    = r_count;
    assign q.level        = r_level;

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed checks of ordering, full/empty, overflow masking/status, wrap, async reset; parity under ALU_RQ_PARITY_EN
module tb_alu_result_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    alu_result_queue_if #(.WIDTH(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) q ();

    alu_result_queue #(.WIDTH(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] r, input logic [1:0] c, input logic o);
        q.in_valid    = 1'b1;
        q.in_result   = r;
        q.in_control  = c;
        q.in_overflow = o;
    endtask

    initial begin
        rst = 1'b1;
        q.in_valid = 1'b0;
        q.in_result = '0;
        q.in_overflow = 1'b0;
        q.in_control = 2'd0;
        q.out_ready = 1'b0;
        q.clr_status = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rst_out_valid", 64'(q.out_valid), 64'd0);
        chk("rst_level", 64'(q.level), 64'd0);
        chk("rst_in_ready", 64'(q.in_ready), 64'd1);
        chk("rst_sticky", 64'(q.ovf_sticky), 64'd0);
        chk("rst_count", 64'(q.ovf_count), 64'd0);
        // 1: single ADD push, visible next cycle, then popped
        q.out_ready = 1'b1;
        push(64'h5, ALU_OP_ADD, 1'b0);
        tick();
        q.in_valid = 1'b0;
        chk("t1_out_valid", 64'(q.out_valid), 64'd1);
        chk("t1_result", q.out_result, 64'h5);
        chk("t1_zero", 64'(q.out_zero), 64'd0);
        chk("t1_level1", 64'(q.level), 64'd1);
        tick();
        chk("t1_level0", 64'(q.level), 64'd0);
        chk("t1_empty", 64'(q.out_valid), 64'd0);
        // 2: fill with stalled consumer; the fifth push is dropped
        q.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(64'(i), ALU_OP_XOR, 1'b0);
            tick();
        end
        chk("t2_full_ready", 64'(q.in_ready), 64'd0);
        chk("t2_full_level", 64'(q.level), 64'd4);
        push(64'd5, ALU_OP_XOR, 1'b0);
        tick();
        q.in_valid = 1'b0;
        chk("t2_drop_level", 64'(q.level), 64'd4);
        q.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_pop_data", q.out_result, 64'(i));
            tick();
            if (i == 1) chk("t2_ready_after_pop", 64'(q.in_ready), 64'd1);
        end
        chk("t2_drained", 64'(q.level), 64'd0);
        q.out_ready = 1'b0;
        // 3: overflow masked for AND, kept for SUB; zero flag on a zero result
        push(64'h0, ALU_OP_SUB, 1'b1);
        tick();
        push(64'h9, ALU_OP_AND, 1'b1);
        tick();
        q.in_valid = 1'b0;
        chk("t3_sticky", 64'(q.ovf_sticky), 64'd1);
        chk("t3_count", 64'(q.ovf_count), 64'd1);
        chk("t3_ovf_sub", 64'(q.out_overflow), 64'd1);
        chk("t3_zero_sub", 64'(q.out_zero), 64'd1);
        chk("t3_ctrl_sub", 64'(q.out_control), 64'd1);
        q.out_ready = 1'b1;
        tick();
        chk("t3_ovf_and", 64'(q.out_overflow), 64'd0);
        chk("t3_zero_and", 64'(q.out_zero), 64'd0);
        chk("t3_ctrl_and", 64'(q.out_control), 64'd2);
        tick();
        chk("t3_level", 64'(q.level), 64'd0);
        // 4: counter saturates at 3, clears, and push-with-overflow wins over clear
        for (int i = 0; i < 5; i++) begin
            push(64'(i + 20), ALU_OP_ADD, 1'b1);
            tick();
        end
        q.in_valid = 1'b0;
        chk("t4_saturate", 64'(q.ovf_count), 64'd3);
        tick();
        q.clr_status = 1'b1;
        tick();
        q.clr_status = 1'b0;
        chk("t4_clr_count", 64'(q.ovf_count), 64'd0);
        chk("t4_clr_sticky", 64'(q.ovf_sticky), 64'd0);
        q.clr_status = 1'b1;
        push(64'h33, ALU_OP_ADD, 1'b1);
        tick();
        q.clr_status = 1'b0;
        q.in_valid = 1'b0;
        chk("t4_win_count", 64'(q.ovf_count), 64'd1);
        chk("t4_win_sticky", 64'(q.ovf_sticky), 64'd1);
        tick();
        chk("t4_level", 64'(q.level), 64'd0);
        // 5: steady push+pop at level 2 across pointer wrap
        q.out_ready = 1'b0;
        push(64'd100, ALU_OP_XOR, 1'b0);
        tick();
        push(64'd101, ALU_OP_XOR, 1'b0);
        tick();
        q.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push(64'(102 + k), ALU_OP_XOR, 1'b0);
            chk("t5_data", q.out_result, 64'(100 + k));
            tick();
            chk("t5_level", 64'(q.level), 64'd2);
        end
        q.in_valid = 1'b0;
        chk("t5_tail0", q.out_result, 64'd110);
        tick();
        chk("t5_tail1", q.out_result, 64'd111);
        tick();
        chk("t5_empty", 64'(q.level), 64'd0);
        // 6: asynchronous reset mid-stream at level 3
        q.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(64'(i + 1), ALU_OP_ADD, 1'b1);
            tick();
        end
        q.in_valid = 1'b0;
        chk("t6_level3", 64'(q.level), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(q.out_valid), 64'd0);
        chk("t6_rst_level", 64'(q.level), 64'd0);
        chk("t6_rst_sticky", 64'(q.ovf_sticky), 64'd0);
        chk("t6_rst_count", 64'(q.ovf_count), 64'd0);
        tick();
        rst = 1'b0;
        tick();
`ifdef ALU_RQ_PARITY_EN
        push(64'h7, ALU_OP_ADD, 1'b0);
        tick();
        q.in_valid = 1'b0;
        chk("par_7", 64'(q.out_parity), 64'd1);
        q.out_ready = 1'b1;
        push(64'h6, ALU_OP_ADD, 1'b0);
        tick();
        q.in_valid = 1'b0;
        chk("par_6", 64'(q.out_parity), 64'd0);
        tick();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
